mux_scan_capture: RTL and testbench
===================================

// Module: mux_scan_capture
//
// PURPOSE
//   Sequential scanner that sits in front of and behind a 16:1 bit multiplexer.
//   Drives the mux select s through 0..N-1 and samples the mux output f at each index.
//   Assembles the samples into an N-bit word and reports completion with a
//   start/busy/done handshake.
//   With a pass-through mux (f = w[s]) the captured word equals the mux data input w.
//
// PARAMETERS
//   SEL_W   4   select width; N = 2**SEL_W inputs scanned (16 at default)
//   SETTLE  1   cycles each select value is held before f is sampled; legal 1..15
//
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request one full scan; sampled only when not busy
//   mux_f   in   1      mux output f for the current select
//   s       out  SEL_W  mux select, registered
//   busy    out  1      high while a scan is in progress
//   done    out  1      one-cycle pulse: word holds a fresh result
//   word    out  [0:N-1]  word[i] = mux_f sampled while s==i; same [0:N-1] ordering as the mux w bus
//
// BEHAVIOUR
//   Reset (async assert, sync release): s=0, busy=0, done=0, word=0.
//   Reset also clears the FSM to IDLE, the hold counter and the shadow register.
//   FSM states: IDLE, SCAN, DONE.
//   - IDLE: s=0, busy=0, done=0. If start=1 at edge E0, go to SCAN.
//     From E0: busy=1, s=0, hold counter loaded with SETTLE-1.
//   - SCAN: s is held for exactly SETTLE cycles per index.
//     On the edge ending the last hold cycle:
//       shadow[s] <= mux_f;
//       if s != N-1: s increments and the counter reloads;
//       if s == N-1: go to DONE.
//   - DONE (one cycle): at the entry edge, word <= shadow (including the final sample).
//     In this cycle done=1, busy=0, s=0.
//     The next edge returns to IDLE, or re-enters SCAN if start=1.
//   Latency: last sample at edge E0+N*SETTLE. done is high for the cycle after that edge.
//     Default parameters: done high during cycle 17 after start.
//   word changes only on DONE entry, so it is stable during a scan.
//     It keeps the previous result until the new scan completes.
//   start while busy=1: ignored, no restart, no queueing.
//   start held high continuously: back-to-back scans separated by exactly one DONE cycle.
//   s wrap: s never passes N-1 inside a scan; it returns to 0 in DONE and stays 0 in IDLE.
//   Reset mid-scan: the scan is aborted and all outputs return to reset values.
//     word is cleared; no done pulse is issued.
//   mux_f is sampled only at the hold-end edges; its value at other times is don't-care.
//
// TESTING
//   1. Reset, then pulse start with a mux model f=w[s], w=16'hACF1
//      -> s steps 0..15, one value per cycle; done pulses once at cycle 17; word==16'hACF1.
//   2. Hold start high with w=16'hCBE3 after the scan from test 1
//      -> word stays 16'hACF1 throughout the scan, becomes 16'hCBE3 at the next done.
//      Exactly one done cycle lies between consecutive scans.
//   3. Pulse start again at s==5 during a scan
//      -> ignored; the scan completes unchanged; a single done pulse.
//   4. Assert rst_n=0 at s==9 mid-scan
//      -> outputs go to 0 immediately (asynchronously); no done pulse.
//      A new start gives a correct full scan.
//   5. SETTLE=3, w=16'h8001
//      -> each s value is held for 3 cycles; done at cycle 49; word==16'h8001, so bit order is checked.
//   6. Drive mux_f to the opposite value during non-sampling hold cycles (SETTLE=3)
//      -> word is unaffected; only hold-end samples count.

Source files
------------

// File: rtl/mux_scan_capture_if.sv
// Handshake and mux-side signals of the scan/capture block.
// The master side requests scans and supplies the mux output; the slave side is the scanner.
interface mux_scan_capture_if #(
  parameter int unsigned SEL_W = 4
) ();
  localparam int unsigned N = 2 ** SEL_W;

  logic             start;
  logic             mux_f;
  logic [SEL_W-1:0] s;
  logic             busy;
  logic             done;
  logic [0:N-1]     word;

  modport master (
    output start,
    output mux_f,
    input  s,
    input  busy,
    input  done,
    input  word
  );

  modport slave (
    input  start,
    input  mux_f,
    output s,
    output busy,
    output done,
    output word
  );
endinterface

// File: rtl/mux_scan_capture.sv
// Steps a mux select through every index, samples the mux output once per index after a
// settle period, and publishes the assembled word with a start/busy/done handshake.
module mux_scan_capture #(
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  mux_scan_capture_if.slave bus
);

  localparam int unsigned     N       = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LastSel = SEL_W'(N - 1);
  localparam logic [3:0]       Reload  = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q;
  logic [3:0]       hold_q;
  logic [SEL_W-1:0] s_q;
  logic             busy_q;
  logic             done_q;
  logic [0:N-1]     shadow_q;
  logic [0:N-1]     word_q;
  logic [0:N-1]     shadow_next;

  // Shadow with the current sample merged in, so DONE entry can publish the final bit too.
  always_comb begin
    shadow_next         = shadow_q;
    shadow_next[s_q]    = bus.mux_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      s_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          s_q    <= '0;
          if (bus.start) begin
            state_q <= StScan;
            busy_q  <= 1'b1;
            hold_q  <= Reload;
          end
        end
        StScan: begin
          if (hold_q == 4'd0) begin
            shadow_q <= shadow_next;
            if (s_q == LastSel) begin
              state_q <= StDone;
              word_q  <= shadow_next;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              s_q     <= '0;
            end else begin
              s_q    <= s_q + SEL_W'(1);
              hold_q <= Reload;
            end
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= StScan;
            busy_q  <= 1'b1;
            hold_q  <= Reload;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          s_q     <= '0;
        end
      endcase
    end
  end

  assign bus.s    = s_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.word = word_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench: one scanner with SETTLE=1 and one with SETTLE=3, each fronting a
// pass-through mux model built from a test word.
module tb_mux_scan_capture;

  logic clk = 1'b0;
  logic rst1_n, rst3_n;
  logic [0:15] w1, w3;
  logic flip3;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_scan_capture_if #(.SEL_W(4)) bus1 ();
  mux_scan_capture_if #(.SEL_W(4)) bus3 ();

  assign bus1.mux_f = w1[bus1.s];
  assign bus3.mux_f = w3[bus3.s] ^ flip3;

  mux_scan_capture #(.SEL_W(4), .SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  mux_scan_capture #(.SEL_W(4), .SETTLE(3)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3)
  );

  // One SETTLE=1 scan starting at the current negedge; returns at the negedge of the done cycle.
  task automatic scan1(input logic [0:15] w, input logic [0:15] prev, input bit keep_start,
                       input int poke_s, input string name);
    logic [3:0] exp_s;
    w1 = w;
    bus1.start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_s = 4'(k - 1);
      if (!keep_start) bus1.start = (k - 1 == poke_s);
      tests++;
      if (bus1.s !== exp_s || bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
        fails++;
        $display("FAIL %s cycle %0d: s=%0d busy=%b done=%b, want s=%0d busy=1 done=0",
                 name, k, bus1.s, bus1.busy, bus1.done, exp_s);
      end
      tests++;
      if (bus1.word !== prev) begin
        fails++;
        $display("FAIL %s word during scan cycle %0d: got %h want %h", name, k, bus1.word, prev);
      end
    end
    @(negedge clk);
    if (!keep_start) bus1.start = 1'b0;
    tests++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.s !== 4'd0 || bus1.word !== w) begin
      fails++;
      $display("FAIL %s done cycle: done=%b busy=%b s=%0d word=%h, want done=1 busy=0 s=0 word=%h",
               name, bus1.done, bus1.busy, bus1.s, bus1.word, w);
    end
  endtask

  // One SETTLE=3 scan; with corrupt set, mux_f is inverted on every non-sampling hold cycle.
  task automatic scan3(input logic [0:15] w, input logic [0:15] prev, input bit corrupt,
                       input string name);
    logic [3:0] exp_s;
    w3 = w;
    bus3.start = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      bus3.start = 1'b0;
      flip3 = corrupt && (k % 3 != 0);
      exp_s = 4'((k - 1) / 3);
      tests++;
      if (bus3.s !== exp_s || bus3.busy !== 1'b1 || bus3.done !== 1'b0 || bus3.word !== prev) begin
        fails++;
        $display("FAIL %s cycle %0d: s=%0d busy=%b done=%b word=%h, want s=%0d busy=1 done=0 word=%h",
                 name, k, bus3.s, bus3.busy, bus3.done, bus3.word, exp_s, prev);
      end
    end
    @(negedge clk);
    flip3 = 1'b0;
    tests++;
    if (bus3.done !== 1'b1 || bus3.busy !== 1'b0 || bus3.s !== 4'd0 || bus3.word !== w) begin
      fails++;
      $display("FAIL %s done cycle 49: done=%b busy=%b s=%0d word=%h, want 1 0 0 %h",
               name, bus3.done, bus3.busy, bus3.s, bus3.word, w);
    end
    @(negedge clk);
    tests++;
    if (bus3.done !== 1'b0 || bus3.busy !== 1'b0 || bus3.word !== w) begin
      fails++;
      $display("FAIL %s after done: done=%b busy=%b word=%h, want 0 0 %h",
               name, bus3.done, bus3.busy, bus3.word, w);
    end
  endtask

  task automatic test_reset();
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    flip3 = 1'b0;
    w1 = '0;
    w3 = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (bus1.s !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.word !== 16'h0) begin
      fails++;
      $display("FAIL reset dut1: s=%0d busy=%b done=%b word=%h, want all zero",
               bus1.s, bus1.busy, bus1.done, bus1.word);
    end
    tests++;
    if (bus3.s !== 4'd0 || bus3.busy !== 1'b0 || bus3.done !== 1'b0 || bus3.word !== 16'h0) begin
      fails++;
      $display("FAIL reset dut3: s=%0d busy=%b done=%b word=%h, want all zero",
               bus3.s, bus3.busy, bus3.done, bus3.word);
    end
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_scan();
    scan1(16'hACF1, 16'h0000, 1'b0, -1, "single_scan");
    @(negedge clk);
    tests++;
    if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.s !== 4'd0 || bus1.word !== 16'hACF1) begin
      fails++;
      $display("FAIL single_scan idle after done: done=%b busy=%b s=%0d word=%h, want 0 0 0 acf1",
               bus1.done, bus1.busy, bus1.s, bus1.word);
    end
  endtask

  task automatic test_back_to_back();
    scan1(16'hCBE3, 16'hACF1, 1'b1, -1, "b2b_first");
    scan1(16'h1234, 16'hCBE3, 1'b1, -1, "b2b_second");
    bus1.start = 1'b0;
    @(negedge clk);
    tests++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b stop: busy=%b done=%b, want 0 0", bus1.busy, bus1.done);
    end
  endtask

  task automatic test_start_while_busy();
    scan1(16'h0F5A, 16'h1234, 1'b0, 5, "start_busy");
    @(negedge clk);
    tests++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.word !== 16'h0F5A) begin
      fails++;
      $display("FAIL start_busy restart: busy=%b done=%b word=%h, want 0 0 0f5a",
               bus1.busy, bus1.done, bus1.word);
    end
  endtask

  task automatic test_reset_mid_scan();
    w1 = 16'hFFFF;
    bus1.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
    end
    tests++;
    if (bus1.s !== 4'd9) begin
      fails++;
      $display("FAIL reset_mid pre: s=%0d want 9", bus1.s);
    end
    #2 rst1_n = 1'b0;
    #1;
    tests++;
    if (bus1.s !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.word !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid async: s=%0d busy=%b done=%b word=%h, want all zero",
               bus1.s, bus1.busy, bus1.done, bus1.word);
    end
    @(negedge clk);
    rst1_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid quiet cycle %0d: done=%b busy=%b, want 0 0",
                 k, bus1.done, bus1.busy);
      end
    end
    scan1(16'h6C39, 16'h0000, 1'b0, -1, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_settle3();
    scan3(16'h8001, 16'h0000, 1'b0, "settle3");
  endtask

  task automatic test_hold_glitch();
    scan3(16'h5A3C, 16'h8001, 1'b1, "hold_glitch");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_scan();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_scan();
    test_settle3();
    test_hold_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
